// File: rtl/jump_sequencer.sv
// Turn sequencer for the jump game: charge on button hold, timed jump arc,
// one-cycle landing evaluation, score update, then scroll back to the home column.
module jump_sequencer #(
   parameter int unsigned HOME_X        = 100,
   parameter int unsigned X_MAX         = 639,
   parameter int unsigned POWER_STEP    = 4,
   parameter int unsigned POWER_MAX     = 400,
   parameter int unsigned STEP_X        = 4,
   parameter int unsigned HSTEP         = 2,
   parameter int unsigned SCROLL        = 4,
   parameter int unsigned PERFECT_BONUS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic        btn,
   input  logic        game_over_in,
   input  logic        middle_in,
   input  logic        on_second_in,
   output logic [9:0]  man_x,
   output logic [7:0]  man_y,
   output logic [9:0]  power,
   output logic [15:0] score,
   output logic        scroll_en,
   output logic        new_game,
   output logic        over,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CHARGE = 3'd1,
      S_JUMP   = 3'd2,
      S_LAND   = 3'd3,
      S_SHIFT  = 3'd4,
      S_OVER   = 3'd5
   } state_t;

   localparam logic [9:0]  HOME_W    = 10'(HOME_X);
   localparam logic [9:0]  XMAX_W    = 10'(X_MAX);
   localparam logic [9:0]  PSTEP_W   = 10'(POWER_STEP);
   localparam logic [9:0]  PMAX_W    = 10'(POWER_MAX);
   localparam logic [9:0]  STEP_W    = 10'(STEP_X);
   localparam logic [7:0]  HSTEP_W   = 8'(HSTEP);
   localparam logic [9:0]  SCROLL_W  = 10'(SCROLL);
   localparam logic [9:0]  SHIFT_LIM = 10'(HOME_X + SCROLL);
   localparam logic [15:0] BONUS_W   = 16'(PERFECT_BONUS);

   state_t      state_q, state_d;
   logic [9:0]  man_x_q, man_x_d;
   logic [7:0]  man_y_q, man_y_d;
   logic [9:0]  power_q, power_d;
   logic [9:0]  rem_q, rem_d;
   logic [15:0] score_q, score_d;
   logic        scroll_en_q, scroll_en_d;
   logic        new_game_q, new_game_d;
   logic        over_q;
   logic        btn_q;

   logic        rise;
   logic [9:0]  jump_step;
   logic [9:0]  rem_after;
   logic        going_up;

   function automatic logic [9:0] add_sat10(input logic [9:0] a, input logic [9:0] b,
                                            input logic [9:0] lim);
      logic [10:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s > {1'b0, lim}) ? lim : s[9:0];
   endfunction

   function automatic logic [15:0] add_sat16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   function automatic logic [7:0] rise_y(input logic [7:0] y);
      return (y > (8'hFF - HSTEP_W)) ? 8'hFF : y + HSTEP_W;
   endfunction

   function automatic logic [7:0] fall_y(input logic [7:0] y);
      return (y > HSTEP_W) ? y - HSTEP_W : 8'd0;
   endfunction

   // Scroll left but never past the home column.
   function automatic logic [9:0] scroll_x(input logic [9:0] x);
      return (x > SHIFT_LIM) ? x - SCROLL_W : HOME_W;
   endfunction

   assign rise      = btn & ~btn_q;
   assign jump_step = (rem_q < STEP_W) ? rem_q : STEP_W;
   assign rem_after = rem_q - jump_step;
   assign going_up  = rem_q > (power_q >> 1);

   always_comb begin
      state_d     = state_q;
      man_x_d     = man_x_q;
      man_y_d     = man_y_q;
      power_d     = power_q;
      rem_d       = rem_q;
      score_d     = score_q;
      scroll_en_d = 1'b0;
      new_game_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rise) begin
               power_d = '0;
               state_d = S_CHARGE;
            end
         end

         // Release wins over a coincident tick so the last tick never adds charge.
         S_CHARGE: begin
            if (!btn) begin
               rem_d   = power_q;
               state_d = S_JUMP;
            end else if (tick) begin
               power_d = add_sat10(power_q, PSTEP_W, PMAX_W);
            end
         end

         S_JUMP: begin
            if (tick) begin
               if (rem_q == '0) begin
                  state_d = S_LAND;
               end else begin
                  man_x_d = add_sat10(man_x_q, jump_step, XMAX_W);
                  rem_d   = rem_after;
                  man_y_d = going_up ? rise_y(man_y_q) : fall_y(man_y_q);
                  if (rem_after == '0) begin
                     man_y_d = '0;
                     state_d = S_LAND;
                  end
               end
            end
         end

         S_LAND: begin
            power_d = '0;
            if (game_over_in) begin
               state_d = S_OVER;
            end else if (on_second_in) begin
               score_d = add_sat16(score_q, middle_in ? BONUS_W : 16'd1);
               state_d = S_SHIFT;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_SHIFT: begin
            if (tick) begin
               scroll_en_d = 1'b1;
               man_x_d     = scroll_x(man_x_q);
               if (scroll_x(man_x_q) == HOME_W) begin
                  state_d = S_IDLE;
               end
            end
         end

         // The restart rise is consumed here; btn_q then blocks a charge in IDLE.
         S_OVER: begin
            if (rise) begin
               man_x_d    = HOME_W;
               man_y_d    = '0;
               score_d    = '0;
               new_game_d = 1'b1;
               state_d    = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         man_x_q     <= HOME_W;
         man_y_q     <= '0;
         power_q     <= '0;
         rem_q       <= '0;
         score_q     <= '0;
         scroll_en_q <= 1'b0;
         new_game_q  <= 1'b0;
         over_q      <= 1'b0;
         btn_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         man_x_q     <= man_x_d;
         man_y_q     <= man_y_d;
         power_q     <= power_d;
         rem_q       <= rem_d;
         score_q     <= score_d;
         scroll_en_q <= scroll_en_d;
         new_game_q  <= new_game_d;
         over_q      <= (state_d == S_OVER);
         btn_q       <= btn;
      end
   end

   assign man_x     = man_x_q;
   assign man_y     = man_y_q;
   assign power     = power_q;
   assign score     = score_q;
   assign scroll_en = scroll_en_q;
   assign new_game  = new_game_q;
   assign over      = over_q;
   assign state     = state_q;

endmodule

// File: tb/tb_jump_sequencer.sv
// Bench for jump_sequencer: directed turn scenarios plus randomized turns,
// all checked against a turn-level model of charge, arc, landing and scroll.
module tb_jump_sequencer;

   logic        clk = 1'b0;
   logic        rst, tick, btn, game_over_in, middle_in, on_second_in;
   logic [9:0]  man_x, power;
   logic [7:0]  man_y;
   logic [15:0] score;
   logic        scroll_en, new_game, over;
   logic [2:0]  state;

   int n_cmp = 0;
   int n_err = 0;
   int m_x = 100;
   int m_score = 0;

   always #5 clk = ~clk;

   jump_sequencer dut (
      .clk(clk), .rst(rst), .tick(tick), .btn(btn),
      .game_over_in(game_over_in), .middle_in(middle_in), .on_second_in(on_second_in),
      .man_x(man_x), .man_y(man_y), .power(power), .score(score),
      .scroll_en(scroll_en), .new_game(new_game), .over(over), .state(state)
   );

   // Model: height after k ticks of a jump launched with charge p.
   function automatic int exp_y(input int p, input int k);
      int y, r;
      y = 0;
      for (int j = 1; j <= k; j++) begin
         r = p - 4 * (j - 1);
         if (r > p / 2) y = y + 2;
         else y = (y >= 2) ? y - 2 : 0;
         if (4 * j >= p) y = 0;
      end
      return y;
   endfunction

   function automatic int exp_x(input int x0, input int p, input int k);
      int v;
      v = x0 + ((4 * k < p) ? 4 * k : p);
      return (v > 639) ? 639 : v;
   endfunction

   function automatic int jump_ticks(input int p);
      return (p == 0) ? 1 : (p + 3) / 4;
   endfunction

   function automatic int sat_score(input int s, input int inc);
      return (s + inc > 65535) ? 65535 : s + inc;
   endfunction

   task automatic clk1();
      @(posedge clk); #1;
   endtask

   task automatic tick1();
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
   endtask

   task automatic press_hold(input int n);
      btn = 1'b1;
      clk1();
      for (int i = 0; i < n; i++) tick1();
   endtask

   task automatic release_btn();
      btn = 1'b0;
      clk1();
   endtask

   task automatic set_checker(input bit go, input bit sec, input bit mid);
      game_over_in = go;
      on_second_in = sec;
      middle_in    = mid;
   endtask

   task automatic shift_home(input int limit, output int n);
      n = 0;
      while (state !== 3'd0 && n < limit) begin
         tick1();
         n++;
         clk1();
      end
   endtask

   task automatic test_reset();
      n_cmp++;
      if (man_x !== 10'd100 || man_y !== 8'd0 || power !== 10'd0 || score !== 16'd0) begin
         n_err++;
         $display("FAIL reset_data: x=%0d y=%0d pw=%0d sc=%0d required 100 0 0 0", man_x, man_y, power, score);
      end
      n_cmp++;
      if (state !== 3'd0 || scroll_en !== 1'b0 || new_game !== 1'b0 || over !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ctrl: st=%0d se=%0b ng=%0b ov=%0b required 0 0 0 0", state, scroll_en, new_game, over);
      end
   endtask

   task automatic test_jump_basic();
      int ys[10] = '{2, 4, 6, 8, 10, 8, 6, 4, 2, 0};
      int x, pulses;
      bit done;
      set_checker(1'b0, 1'b1, 1'b1);
      press_hold(10);
      n_cmp++;
      if (power !== 10'd40 || state !== 3'd1) begin
         n_err++;
         $display("FAIL basic_charge: power=%0d st=%0d required 40 1", power, state);
      end
      release_btn();
      n_cmp++;
      if (state !== 3'd2) begin
         n_err++;
         $display("FAIL basic_release: st=%0d required 2", state);
      end
      for (int k = 0; k < 10; k++) begin
         tick1();
         n_cmp++;
         if (man_y !== 8'(ys[k]) || man_x !== 10'(100 + 4 * (k + 1))) begin
            n_err++;
            $display("FAIL basic_arc tick %0d: x=%0d y=%0d required %0d %0d", k + 1, man_x, man_y, 100 + 4 * (k + 1), ys[k]);
         end
      end
      n_cmp++;
      if (state !== 3'd3) begin
         n_err++;
         $display("FAIL basic_land: st=%0d required 3", state);
      end
      clk1();
      m_score = sat_score(m_score, 2);
      n_cmp++;
      if (state !== 3'd4 || score !== 16'(m_score) || power !== 10'd0) begin
         n_err++;
         $display("FAIL basic_score: st=%0d sc=%0d pw=%0d required 4 %0d 0", state, score, power, m_score);
      end
      x = 140; pulses = 0; done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         tick1();
         pulses++;
         x = (x <= 104) ? 100 : x - 4;
         done = (x == 100);
         n_cmp++;
         if (man_x !== 10'(x) || scroll_en !== 1'b1) begin
            n_err++;
            $display("FAIL basic_scroll: x=%0d se=%0b required %0d 1", man_x, scroll_en, x);
         end
         clk1();
         n_cmp++;
         if (scroll_en !== 1'b0) begin
            n_err++;
            $display("FAIL basic_scroll_pulse: se=%0b required 0", scroll_en);
         end
      end
      n_cmp++;
      if (pulses != 10 || state !== 3'd0 || man_x !== 10'd100) begin
         n_err++;
         $display("FAIL basic_home: pulses=%0d st=%0d x=%0d required 10 0 100", pulses, state, man_x);
      end
      m_x = 100;
   endtask

   task automatic test_over();
      set_checker(1'b1, 1'b1, 1'b1);
      press_hold(3);
      release_btn();
      for (int k = 0; k < 3; k++) tick1();
      clk1();
      n_cmp++;
      if (state !== 3'd5 || over !== 1'b1 || score !== 16'(m_score) || man_x !== 10'(m_x + 12)) begin
         n_err++;
         $display("FAIL over_enter: st=%0d ov=%0b sc=%0d x=%0d required 5 1 %0d %0d", state, over, score, man_x, m_score, m_x + 12);
      end
      for (int k = 0; k < 4; k++) tick1();
      n_cmp++;
      if (state !== 3'd5 || man_x !== 10'(m_x + 12) || power !== 10'd0 || score !== 16'(m_score)) begin
         n_err++;
         $display("FAIL over_frozen: st=%0d x=%0d pw=%0d sc=%0d required 5 %0d 0 %0d", state, man_x, power, score, m_x + 12, m_score);
      end
      set_checker(1'b0, 1'b0, 1'b0);
      btn = 1'b1;
      clk1();
      m_x = 100; m_score = 0;
      n_cmp++;
      if (new_game !== 1'b1 || score !== 16'd0 || man_x !== 10'd100 || man_y !== 8'd0 || state !== 3'd0 || over !== 1'b0) begin
         n_err++;
         $display("FAIL over_restart: ng=%0b sc=%0d x=%0d y=%0d st=%0d ov=%0b required 1 0 100 0 0 0", new_game, score, man_x, man_y, state, over);
      end
      clk1();
      n_cmp++;
      if (new_game !== 1'b0) begin
         n_err++;
         $display("FAIL over_newgame_pulse: ng=%0b required 0", new_game);
      end
      for (int k = 0; k < 20; k++) begin
         tick1();
         n_cmp++;
         if (state !== 3'd0 || power !== 10'd0) begin
            n_err++;
            $display("FAIL over_held_btn: st=%0d pw=%0d required 0 0", state, power);
         end
      end
      release_btn();
   endtask

   task automatic test_zero_power();
      set_checker(1'b0, 1'b1, 1'b0);
      btn = 1'b1;
      clk1();
      release_btn();
      n_cmp++;
      if (state !== 3'd2 || power !== 10'd0) begin
         n_err++;
         $display("FAIL zero_jump: st=%0d pw=%0d required 2 0", state, power);
      end
      tick1();
      n_cmp++;
      if (state !== 3'd3 || man_x !== 10'(m_x) || man_y !== 8'd0) begin
         n_err++;
         $display("FAIL zero_land: st=%0d x=%0d y=%0d required 3 %0d 0", state, man_x, man_y, m_x);
      end
      clk1();
      m_score = sat_score(m_score, 1);
      n_cmp++;
      if (state !== 3'd4 || score !== 16'(m_score)) begin
         n_err++;
         $display("FAIL zero_score: st=%0d sc=%0d required 4 %0d", state, score, m_score);
      end
      tick1();
      n_cmp++;
      if (state !== 3'd0 || man_x !== 10'd100 || scroll_en !== 1'b1) begin
         n_err++;
         $display("FAIL zero_home_shift: st=%0d x=%0d se=%0b required 0 100 1", state, man_x, scroll_en);
      end
      clk1();
   endtask

   task automatic test_release_tick();
      set_checker(1'b0, 1'b0, 1'b0);
      press_hold(2);
      n_cmp++;
      if (power !== 10'd8) begin
         n_err++;
         $display("FAIL reltick_charge: power=%0d required 8", power);
      end
      btn = 1'b0;
      tick1();
      n_cmp++;
      if (state !== 3'd2 || power !== 10'd8) begin
         n_err++;
         $display("FAIL reltick_priority: st=%0d pw=%0d required 2 8", state, power);
      end
      tick1();
      tick1();
      n_cmp++;
      if (state !== 3'd3 || man_x !== 10'(m_x + 8)) begin
         n_err++;
         $display("FAIL reltick_land: st=%0d x=%0d required 3 %0d", state, man_x, m_x + 8);
      end
      clk1();
      m_x = m_x + 8;
      n_cmp++;
      if (state !== 3'd0 || score !== 16'(m_score) || man_x !== 10'(m_x)) begin
         n_err++;
         $display("FAIL reltick_stay: st=%0d sc=%0d x=%0d required 0 %0d %0d", state, score, man_x, m_score, m_x);
      end
   endtask

   task automatic test_held_across_land();
      set_checker(1'b0, 1'b0, 1'b0);
      press_hold(1);
      release_btn();
      btn = 1'b1;
      clk1();
      n_cmp++;
      if (state !== 3'd2) begin
         n_err++;
         $display("FAIL held_in_jump: st=%0d required 2", state);
      end
      tick1();
      clk1();
      m_x = m_x + 4;
      for (int k = 0; k < 3; k++) tick1();
      n_cmp++;
      if (state !== 3'd0 || power !== 10'd0 || man_x !== 10'(m_x)) begin
         n_err++;
         $display("FAIL held_after_land: st=%0d pw=%0d x=%0d required 0 0 %0d", state, power, man_x, m_x);
      end
      release_btn();
   endtask

   task automatic test_saturation();
      int n;
      set_checker(1'b0, 1'b0, 1'b0);
      press_hold(150);
      n_cmp++;
      if (power !== 10'd400) begin
         n_err++;
         $display("FAIL sat_power: power=%0d required 400", power);
      end
      release_btn();
      for (int k = 0; k < 100; k++) tick1();
      m_x = exp_x(m_x, 400, 100);
      n_cmp++;
      if (state !== 3'd3 || man_x !== 10'(m_x) || man_y !== 8'd0) begin
         n_err++;
         $display("FAIL sat_jump1: st=%0d x=%0d y=%0d required 3 %0d 0", state, man_x, man_y, m_x);
      end
      clk1();
      force dut.score_q = 16'hFFFE;
      clk1();
      release dut.score_q;
      m_score = 65534;
      set_checker(1'b0, 1'b1, 1'b1);
      press_hold(150);
      release_btn();
      for (int k = 0; k < 100; k++) tick1();
      n_cmp++;
      if (man_x !== 10'd639) begin
         n_err++;
         $display("FAIL sat_xmax: x=%0d required 639", man_x);
      end
      clk1();
      m_score = sat_score(m_score, 2);
      n_cmp++;
      if (score !== 16'hFFFF || state !== 3'd4) begin
         n_err++;
         $display("FAIL sat_score1: sc=%0h st=%0d required ffff 4", score, state);
      end
      shift_home(300, n);
      n_cmp++;
      if (n != (639 - 100 + 3) / 4 || man_x !== 10'd100 || state !== 3'd0) begin
         n_err++;
         $display("FAIL sat_shift: pulses=%0d x=%0d st=%0d required %0d 100 0", n, man_x, state, (639 - 100 + 3) / 4);
      end
      m_x = 100;
      press_hold(1);
      release_btn();
      tick1();
      clk1();
      m_score = sat_score(m_score, 2);
      n_cmp++;
      if (score !== 16'(m_score) || state !== 3'd4) begin
         n_err++;
         $display("FAIL sat_score2: sc=%0h st=%0d required %0h 4", score, state, m_score);
      end
      shift_home(10, n);
      n_cmp++;
      if (n != 1 || man_x !== 10'd100) begin
         n_err++;
         $display("FAIL sat_shift2: pulses=%0d x=%0d required 1 100", n, man_x);
      end
   endtask

   task automatic test_random();
      int n, p, t, x0, x;
      bit sec, mid, done;
      for (int turn = 0; turn < 8; turn++) begin
         n   = $urandom_range(0, 15);
         sec = 1'($urandom_range(0, 1));
         mid = 1'($urandom_range(0, 1));
         set_checker(1'b0, sec, mid);
         p = (4 * n > 400) ? 400 : 4 * n;
         btn = 1'b1;
         clk1();
         for (int i = 0; i < n; i++) begin
            tick1();
            if ($urandom_range(0, 1) == 1) clk1();
         end
         n_cmp++;
         if (power !== 10'(p) || state !== 3'd1) begin
            n_err++;
            $display("FAIL rand_charge turn %0d: power=%0d st=%0d required %0d 1", turn, power, state, p);
         end
         release_btn();
         t = jump_ticks(p);
         x0 = m_x;
         for (int k = 1; k <= t; k++) begin
            if ($urandom_range(0, 2) == 0) clk1();
            tick1();
            n_cmp++;
            if (man_x !== 10'(exp_x(x0, p, k)) || man_y !== 8'(exp_y(p, k))) begin
               n_err++;
               $display("FAIL rand_arc turn %0d tick %0d: x=%0d y=%0d required %0d %0d", turn, k, man_x, man_y, exp_x(x0, p, k), exp_y(p, k));
            end
         end
         n_cmp++;
         if (state !== 3'd3) begin
            n_err++;
            $display("FAIL rand_land turn %0d: st=%0d required 3", turn, state);
         end
         m_x = exp_x(x0, p, t);
         clk1();
         if (sec) m_score = sat_score(m_score, mid ? 2 : 1);
         n_cmp++;
         if (score !== 16'(m_score) || state !== (sec ? 3'd4 : 3'd0) || power !== 10'd0) begin
            n_err++;
            $display("FAIL rand_outcome turn %0d: sc=%0d st=%0d pw=%0d required %0d %0d 0", turn, score, state, power, m_score, sec ? 4 : 0);
         end
         if (sec) begin
            x = m_x; done = 1'b0;
            for (int i = 0; i < 200 && !done; i++) begin
               tick1();
               x = (x <= 104) ? 100 : x - 4;
               done = (x == 100);
               n_cmp++;
               if (man_x !== 10'(x) || scroll_en !== 1'b1 || state !== (done ? 3'd0 : 3'd4)) begin
                  n_err++;
                  $display("FAIL rand_scroll turn %0d: x=%0d se=%0b st=%0d required %0d 1 %0d", turn, man_x, scroll_en, state, x, done ? 0 : 4);
               end
               clk1();
            end
            m_x = 100;
         end
      end
   endtask

   task automatic test_reset_mid_jump();
      set_checker(1'b0, 1'b0, 1'b0);
      press_hold(10);
      release_btn();
      for (int k = 0; k < 5; k++) tick1();
      n_cmp++;
      if (state !== 3'd2 || man_x !== 10'(exp_x(m_x, 40, 5)) || man_y !== 8'd10) begin
         n_err++;
         $display("FAIL rstmid_pre: st=%0d x=%0d y=%0d required 2 %0d 10", state, man_x, man_y, exp_x(m_x, 40, 5));
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (state !== 3'd0 || man_x !== 10'd100 || man_y !== 8'd0 || power !== 10'd0 || score !== 16'd0 ||
          scroll_en !== 1'b0 || new_game !== 1'b0 || over !== 1'b0) begin
         n_err++;
         $display("FAIL rstmid_async: st=%0d x=%0d y=%0d pw=%0d sc=%0d required 0 100 0 0 0", state, man_x, man_y, power, score);
      end
      btn = 1'b1;
      for (int k = 0; k < 3; k++) tick1();
      n_cmp++;
      if (state !== 3'd0 || man_x !== 10'd100 || man_y !== 8'd0) begin
         n_err++;
         $display("FAIL rstmid_hold: st=%0d x=%0d y=%0d required 0 100 0", state, man_x, man_y);
      end
      btn = 1'b0;
      rst = 1'b0;
      m_x = 100; m_score = 0;
      tick1();
      n_cmp++;
      if (state !== 3'd0 || man_x !== 10'd100) begin
         n_err++;
         $display("FAIL rstmid_after: st=%0d x=%0d required 0 100", state, man_x);
      end
   endtask

   initial begin
      rst = 1'b1;
      tick = 1'b0;
      btn = 1'b0;
      set_checker(1'b0, 1'b0, 1'b0);
      repeat (3) clk1();
      test_reset();
      rst = 1'b0;
      repeat (2) clk1();
      test_jump_basic();
      test_over();
      test_zero_power();
      test_release_tick();
      test_held_across_land();
      test_saturation();
      test_random();
      test_reset_mid_jump();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
